// File: rtl/edge_mon_pkg.sv
// edge_mon_pkg: shared FSM state encoding and default widths for the edge run monitor
package edge_mon_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH_RUN = 2'd1, LOW_RUN = 2'd2} state_e;
    localparam int unsigned CW_DEF = 8;
    localparam int unsigned LW_DEF = 10;
endpackage

// File: rtl/edge_run_monitor_sat_counter.sv
// sat_counter: saturating up-counter with sync clear and load-to-one
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         ret_n,
    input  logic         inc,
    input  logic         clr,
    input  logic         load1,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : load1 ? W'(1) : (inc && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk)
        if (!ret_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt = cnt_q;
endmodule

// File: rtl/edge_run_monitor.sv
// edge_run_monitor: edge counting, run-length measurement and 1-deep run record handshake
module edge_run_monitor
    import edge_mon_pkg::*;
#(
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned LW = LW_DEF
) (
    input  logic          clk,
    input  logic          ret_n,
    input  logic          q_in,
    input  logic          p_in,
    input  logic          clr,
    output logic [CW-1:0] rise_cnt,
    output logic [CW-1:0] fall_cnt,
    output logic [LW-1:0] run_len,
    output logic          run_lvl,
    output logic          run_valid,
    input  logic          run_ready,
    output logic          ovf,
    output logic [1:0]    state
);
    state_e        state_q, state_d;
    logic          rise, fall, publish, pub_lvl, in_run, accept, drop, load;
    logic [LW-1:0] len, run_len_q, run_len_d;
    logic          run_lvl_q, run_lvl_d, run_valid_q, run_valid_d, ovf_q, ovf_d;

    assign rise = q_in & ~p_in;
    assign fall = ~q_in & p_in;

    always_ff @(posedge clk)
        if (!ret_n) state_q <= IDLE;
        else        state_q <= state_d;

    // Any edge starts a run at the new level, whether or not it was expected
    always_comb state_d = rise ? HIGH_RUN : fall ? LOW_RUN : state_q;

    always_comb begin
        publish = (state_q == HIGH_RUN && fall) || (state_q == LOW_RUN && rise);
        pub_lvl = state_q == HIGH_RUN;
        in_run  = state_q != IDLE;
    end

    sat_counter #(.W(CW)) u_rise (
        .clk(clk), .ret_n(ret_n), .inc(rise), .clr(clr), .load1(1'b0), .cnt(rise_cnt)
    );
    sat_counter #(.W(CW)) u_fall (
        .clk(clk), .ret_n(ret_n), .inc(fall), .clr(clr), .load1(1'b0), .cnt(fall_cnt)
    );
    sat_counter #(.W(LW)) u_len (
        .clk(clk), .ret_n(ret_n), .inc(in_run & ~(rise | fall)), .clr(1'b0),
        .load1(rise | fall), .cnt(len)
    );

    // A publish while the held record is still unaccepted is lost and flagged
    always_comb begin
        accept      = run_valid_q & run_ready;
        drop        = publish & run_valid_q & ~run_ready;
        load        = publish & ~drop;
        run_valid_d = load | (run_valid_q & ~accept);
        run_len_d   = load ? len : run_len_q;
        run_lvl_d   = load ? pub_lvl : run_lvl_q;
        ovf_d       = ~clr & (ovf_q | drop);
    end

    always_ff @(posedge clk)
        if (!ret_n) begin
            run_len_q   <= '0;
            run_lvl_q   <= 1'b0;
            run_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            run_len_q   <= run_len_d;
            run_lvl_q   <= run_lvl_d;
            run_valid_q <= run_valid_d;
            ovf_q       <= ovf_d;
        end

    assign run_len   = run_len_q;
    assign run_lvl   = run_lvl_q;
    assign run_valid = run_valid_q;
    assign ovf       = ovf_q;
    assign state     = state_q;
endmodule
